// File: rtl/operand_capture_station_pkg.sv
// Shared types and width helper for the operand capture station and its entries.
package operand_capture_station_pkg;

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_READY   = 2'd2
    } entry_state_t;

    // Index width that never collapses to zero bits for single-element spaces.
    function automatic int width_of(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/operand_capture_station_capture_entry.sv
// One operation entry: state register, two operand records and per-bus tag snooping.
// Optional macro ALLOC_BUS_BYPASS_EN lets a newly loaded operand capture same-cycle broadcasts.
module capture_entry
    import operand_capture_station_pkg::*;
#(
    parameter int SIZE      = 32,
    parameter int TAG_W     = 2,
    parameter int BUS_COUNT = 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                load,
    input  logic                                retire,
    input  logic                                alloc_a_pending,
    input  logic [TAG_W-1:0]                    alloc_a_tag,
    input  logic [SIZE-1:0]                     alloc_a_value,
    input  logic                                alloc_b_pending,
    input  logic [TAG_W-1:0]                    alloc_b_tag,
    input  logic [SIZE-1:0]                     alloc_b_value,
    input  logic [BUS_COUNT-1:0]                bus_asserted,
    input  logic [BUS_COUNT-1:0][TAG_W-1:0]     bus_source,
    input  logic [BUS_COUNT-1:0][SIZE-1:0]      bus_value,
    output logic                                is_free,
    output logic                                is_ready,
    output logic [SIZE-1:0]                     operand_a,
    output logic [SIZE-1:0]                     operand_b
);

    typedef struct packed {
        logic             pending;
        logic [TAG_W-1:0] tag;
        logic [SIZE-1:0]  value;
    } operand_t;

    entry_state_t state, state_n;
    operand_t     op_a, op_a_n, op_b, op_b_n;

    // Scanning from the highest bus down leaves the lowest matching bus as the winner.
    function automatic operand_t snoop(input operand_t op);
        operand_t r;
        r = op;
        if (op.pending) begin
            for (int j = BUS_COUNT - 1; j >= 0; j--) begin
                if (bus_asserted[j] && (bus_source[j] == op.tag)) begin
                    r.pending = 1'b0;
                    r.value   = bus_value[j];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_n = state;
        op_a_n  = op_a;
        op_b_n  = op_b;
        if (flush) begin
            state_n = ST_FREE;
        end else begin
            case (state)
                ST_FREE: begin
                    if (load) begin
                        op_a_n = '{pending: alloc_a_pending, tag: alloc_a_tag, value: alloc_a_value};
                        op_b_n = '{pending: alloc_b_pending, tag: alloc_b_tag, value: alloc_b_value};
`ifdef ALLOC_BUS_BYPASS_EN
                        op_a_n = snoop(op_a_n);
                        op_b_n = snoop(op_b_n);
`endif
                        state_n = (op_a_n.pending || op_b_n.pending) ? ST_WAITING : ST_READY;
                    end
                end
                ST_WAITING: begin
                    op_a_n  = snoop(op_a);
                    op_b_n  = snoop(op_b);
                    state_n = (op_a_n.pending || op_b_n.pending) ? ST_WAITING : ST_READY;
                end
                ST_READY: begin
                    if (retire) state_n = ST_FREE;
                end
                default: state_n = ST_FREE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_FREE;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            state <= state_n;
            op_a  <= op_a_n;
            op_b  <= op_b_n;
        end
    end

    assign is_free   = (state == ST_FREE);
    assign is_ready  = (state == ST_READY);
    assign operand_a = op_a.value;
    assign operand_b = op_b.value;

endmodule

// File: rtl/operand_capture_station.sv
// Operand capture station: holds in-flight operations, snoops result buses, issues resolved entries.
// Optional macro ALLOC_BUS_BYPASS_EN enables same-cycle bus capture at allocation.
module operand_capture_station
    import operand_capture_station_pkg::*;
#(
    parameter  int SIZE          = 32,
    parameter  int STATION_COUNT = 4,
    parameter  int BUS_COUNT     = 1,
    parameter  int ENTRY_COUNT   = 4,
    localparam int TAG_W         = width_of(STATION_COUNT),
    localparam int IDX_W         = width_of(ENTRY_COUNT)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic                          alloc_a_pending,
    input  logic                          alloc_b_pending,
    input  logic [TAG_W-1:0]              alloc_a_tag,
    input  logic [TAG_W-1:0]              alloc_b_tag,
    input  logic [SIZE-1:0]               alloc_a_value,
    input  logic [SIZE-1:0]               alloc_b_value,
    input  logic [BUS_COUNT-1:0]          bus_asserted_flat,
    input  logic [BUS_COUNT*TAG_W-1:0]    bus_source_flat,
    input  logic [BUS_COUNT*SIZE-1:0]     bus_value_flat,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [IDX_W-1:0]              issue_entry,
    output logic [SIZE-1:0]               issue_a,
    output logic [SIZE-1:0]               issue_b
);

    logic [BUS_COUNT-1:0][TAG_W-1:0] bus_source;
    logic [BUS_COUNT-1:0][SIZE-1:0]  bus_value;

    assign bus_source = bus_source_flat;
    assign bus_value  = bus_value_flat;

    logic [ENTRY_COUNT-1:0] is_free, is_ready, load, retire;
    logic [SIZE-1:0]        operand_a [ENTRY_COUNT];
    logic [SIZE-1:0]        operand_b [ENTRY_COUNT];
    logic [IDX_W-1:0]       free_idx;

    // Descending scan so the lowest-index FREE/READY entry is the one left selected.
    always_comb begin
        free_idx    = '0;
        issue_entry = '0;
        alloc_ready = 1'b0;
        issue_valid = 1'b0;
        for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
            if (is_free[i]) begin
                free_idx    = IDX_W'(i);
                alloc_ready = 1'b1;
            end
            if (is_ready[i]) begin
                issue_entry = IDX_W'(i);
                issue_valid = 1'b1;
            end
        end
    end

    assign issue_a = issue_valid ? operand_a[issue_entry] : '0;
    assign issue_b = issue_valid ? operand_b[issue_entry] : '0;

    for (genvar i = 0; i < ENTRY_COUNT; i++) begin : g_entry
        assign load[i]   = alloc_valid && alloc_ready && (free_idx == IDX_W'(i));
        assign retire[i] = issue_valid && issue_ready && (issue_entry == IDX_W'(i));

        capture_entry #(
            .SIZE      (SIZE),
            .TAG_W     (TAG_W),
            .BUS_COUNT (BUS_COUNT)
        ) u_entry (
            .clock           (clock),
            .reset           (reset),
            .flush           (flush),
            .load            (load[i]),
            .retire          (retire[i]),
            .alloc_a_pending (alloc_a_pending),
            .alloc_a_tag     (alloc_a_tag),
            .alloc_a_value   (alloc_a_value),
            .alloc_b_pending (alloc_b_pending),
            .alloc_b_tag     (alloc_b_tag),
            .alloc_b_value   (alloc_b_value),
            .bus_asserted    (bus_asserted_flat),
            .bus_source      (bus_source),
            .bus_value       (bus_value),
            .is_free         (is_free[i]),
            .is_ready        (is_ready[i]),
            .operand_a       (operand_a[i]),
            .operand_b       (operand_b[i])
        );
    end

endmodule

// File: tb/tb_operand_capture_station.sv
// Directed and randomized bench for operand_capture_station with two snooped buses.
module tb_operand_capture_station;

    localparam int NE = 4;
    localparam int NB = 2;

    logic              clock, reset, flush;
    logic              alloc_valid, alloc_ready;
    logic              alloc_a_pending, alloc_b_pending;
    logic [1:0]        alloc_a_tag, alloc_b_tag;
    logic [31:0]       alloc_a_value, alloc_b_value;
    logic [NB-1:0]     bus_asr;
    logic [NB-1:0][1:0]  bus_src;
    logic [NB-1:0][31:0] bus_val;
    logic              issue_valid, issue_ready;
    logic [1:0]        issue_entry;
    logic [31:0]       issue_a, issue_b;

    int vectors = 0;
    int miscompares = 0;

    operand_capture_station #(
        .SIZE(32), .STATION_COUNT(4), .BUS_COUNT(NB), .ENTRY_COUNT(NE)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .alloc_a_pending   (alloc_a_pending),
        .alloc_b_pending   (alloc_b_pending),
        .alloc_a_tag       (alloc_a_tag),
        .alloc_b_tag       (alloc_b_tag),
        .alloc_a_value     (alloc_a_value),
        .alloc_b_value     (alloc_b_value),
        .bus_asserted_flat (bus_asr),
        .bus_source_flat   (bus_src),
        .bus_value_flat    (bus_val),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_entry       (issue_entry),
        .issue_a           (issue_a),
        .issue_b           (issue_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: an occupied slot plus per-operand "still waiting on tag" flags.
    bit          m_busy [NE];
    bit          m_ap [NE], m_bp [NE];
    logic [1:0]  m_at [NE], m_bt [NE];
    logic [31:0] m_av [NE], m_bv [NE];

    function automatic int first_ready();
        for (int i = 0; i < NE; i++)
            if (m_busy[i] && !m_ap[i] && !m_bp[i]) return i;
        return -1;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < NE; i++)
            if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic bit bus_hit(input logic [1:0] tag, output logic [31:0] v);
        v = '0;
        for (int j = 0; j < NB; j++)
            if (bus_asr[j] && bus_src[j] == tag) begin
                v = bus_val[j];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NE; i++) begin
            m_busy[i] = 0; m_ap[i] = 0; m_bp[i] = 0;
            m_at[i] = 0; m_bt[i] = 0; m_av[i] = 0; m_bv[i] = 0;
        end
    endtask

    task automatic model_update();
        int rsel, fsel;
        logic [31:0] v;
        rsel = first_ready();
        fsel = first_free();
        if (flush) begin
            for (int i = 0; i < NE; i++) m_busy[i] = 0;
            return;
        end
        for (int i = 0; i < NE; i++) begin
            if (m_busy[i] && m_ap[i] && bus_hit(m_at[i], v)) begin m_ap[i] = 0; m_av[i] = v; end
            if (m_busy[i] && m_bp[i] && bus_hit(m_bt[i], v)) begin m_bp[i] = 0; m_bv[i] = v; end
        end
        if (rsel >= 0 && issue_ready) m_busy[rsel] = 0;
        if (alloc_valid && fsel >= 0) begin
            m_busy[fsel] = 1;
            m_ap[fsel] = alloc_a_pending; m_at[fsel] = alloc_a_tag; m_av[fsel] = alloc_a_value;
            m_bp[fsel] = alloc_b_pending; m_bt[fsel] = alloc_b_tag; m_bv[fsel] = alloc_b_value;
`ifdef ALLOC_BUS_BYPASS_EN
            if (m_ap[fsel] && bus_hit(m_at[fsel], v)) begin m_ap[fsel] = 0; m_av[fsel] = v; end
            if (m_bp[fsel] && bus_hit(m_bt[fsel], v)) begin m_bp[fsel] = 0; m_bv[fsel] = v; end
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int r;
        r = first_ready();
        chk("issue_valid", {31'b0, issue_valid}, {31'b0, r >= 0});
        chk("alloc_ready", {31'b0, alloc_ready}, {31'b0, first_free() >= 0});
        chk("issue_entry", {30'b0, issue_entry}, (r >= 0) ? r : 0);
        chk("issue_a", issue_a, (r >= 0) ? m_av[r] : 32'h0);
        chk("issue_b", issue_b, (r >= 0) ? m_bv[r] : 32'h0);
    endtask

    task automatic cycle();
        model_update();
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle();
        flush = 0; alloc_valid = 0; issue_ready = 0;
        alloc_a_pending = 0; alloc_b_pending = 0;
        alloc_a_tag = 0; alloc_b_tag = 0;
        alloc_a_value = $urandom; alloc_b_value = $urandom;
        bus_asr = '0; bus_src = '0; bus_val = {$urandom, $urandom};
    endtask

    task automatic set_alloc(input bit ap, input logic [1:0] at, input logic [31:0] av,
                             input bit bp, input logic [1:0] bt, input logic [31:0] bv);
        alloc_valid = 1;
        alloc_a_pending = ap; alloc_a_tag = at; alloc_a_value = av;
        alloc_b_pending = bp; alloc_b_tag = bt; alloc_b_value = bv;
    endtask

    task automatic bcast(input int j, input logic [1:0] src, input logic [31:0] val);
        bus_asr[j] = 1'b1; bus_src[j] = src; bus_val[j] = val;
    endtask

    initial begin
        reset = 1;
        idle();
        model_clear();
        @(negedge clock);
        check_outputs();
        reset = 0;

        // Immediate operands issue the next cycle.
        set_alloc(0, 0, 32'd5, 0, 0, 32'd7);
        cycle();
        chk("t1_valid", {31'b0, issue_valid}, 1);
        chk("t1_a", issue_a, 5);
        chk("t1_b", issue_b, 7);
        idle(); issue_ready = 1;
        cycle();

        // Pending operand resolved by a later broadcast; wrong tag ignored.
        idle(); set_alloc(1, 2'd2, 32'hFFFF, 0, 0, 32'd9);
        cycle();
        idle(); bcast(0, 2'd1, 32'hDEAD);
        cycle();
        chk("t2_wait", {31'b0, issue_valid}, 0);
        idle(); bcast(0, 2'd2, 32'h1234);
        cycle();
        chk("t2_a", issue_a, 32'h1234);
        chk("t2_b", issue_b, 9);
        idle(); issue_ready = 1;
        cycle();

        // Two buses resolve two entries in one cycle; they issue in index order.
        idle(); set_alloc(1, 2'd1, 0, 0, 0, 32'd11);
        cycle();
        idle(); set_alloc(0, 0, 32'd22, 1, 2'd3, 0);
        cycle();
        idle(); bcast(0, 2'd1, 32'hA1); bcast(1, 2'd3, 32'hB3);
        cycle();
        chk("t3_first", {30'b0, issue_entry}, 0);
        idle(); issue_ready = 1;
        cycle();
        chk("t3_second", {30'b0, issue_entry}, 1);
        chk("t3_b", issue_b, 32'hB3);
        cycle();

        // Fill, ignored alloc while full, then ordered drain.
        for (int k = 0; k < NE; k++) begin
            idle(); set_alloc(1, 2'd0, 0, 0, 0, k);
            cycle();
        end
        chk("t4_full", {31'b0, alloc_ready}, 0);
        idle(); set_alloc(0, 0, 32'd99, 0, 0, 32'd99);
        cycle();
        idle(); bcast(1, 2'd0, 32'hABCD);
        cycle();
        idle(); issue_ready = 1;
        for (int k = 0; k < NE; k++) begin
            chk("t4_order", {30'b0, issue_entry}, k);
            cycle();
        end

        // Allocation racing a same-cycle broadcast of its tag.
        idle(); set_alloc(1, 2'd1, 0, 0, 0, 32'd3); bcast(0, 2'd1, 32'd42);
        cycle();
`ifdef ALLOC_BUS_BYPASS_EN
        chk("t5_bypass", issue_a, 42);
`else
        chk("t5_nobypass", {31'b0, issue_valid}, 0);
`endif
        idle(); flush = 1;
        cycle();

        // Flush drops waiting entries; stale broadcasts then do nothing.
        for (int k = 1; k < 4; k++) begin
            idle(); set_alloc(1, k, 0, 0, 0, k);
            cycle();
        end
        idle(); flush = 1; issue_ready = 1;
        cycle();
        chk("t6_flush_ready", {31'b0, alloc_ready}, 1);
        idle(); bcast(0, 2'd1, 32'h1); bcast(1, 2'd2, 32'h2);
        cycle();
        chk("t6_flush_valid", {31'b0, issue_valid}, 0);

        // Asynchronous reset between edges with entries waiting.
        for (int k = 1; k < 4; k++) begin
            idle(); set_alloc(1, k, 0, 1, k, k);
            cycle();
        end
        idle();
        #2 reset = 1;
        model_clear();
        #1 check_outputs();
        @(negedge clock);
        reset = 0;
        idle(); bcast(0, 2'd3, 32'h33);
        cycle();
        chk("t7_reset_valid", {31'b0, issue_valid}, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            flush           = ($urandom_range(0, 49) == 0);
            alloc_valid     = $urandom_range(0, 1);
            issue_ready     = ($urandom_range(0, 3) != 0);
            alloc_a_pending = ($urandom_range(0, 2) != 0);
            alloc_b_pending = ($urandom_range(0, 2) != 0);
            alloc_a_tag     = 2'($urandom_range(0, 3));
            alloc_b_tag     = 2'($urandom_range(0, 3));
            alloc_a_value   = $urandom;
            alloc_b_value   = $urandom;
            for (int j = 0; j < NB; j++) begin
                bus_asr[j] = ($urandom_range(0, 2) != 0);
                bus_src[j] = 2'($urandom_range(0, 3));
                bus_val[j] = $urandom;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
